// File: rtl/gmm_dma_pkg.sv
// Shared types and constants for the GMM DMA descriptor chain builder:
// descriptor layout, control words, prefetcher CSR map and FSM states.
package gmm_dma_pkg;

  localparam logic [2:0]  CSR_CTL        = 3'd0;
  localparam logic [2:0]  CSR_DESC_LO    = 3'd1;
  localparam logic [2:0]  CSR_DESC_HI    = 3'd2;
  localparam logic [31:0] PREF_STOP_WORD = 32'h0000_0004;

  typedef struct packed {
    logic       go;
    logic       owned_by_hw;
    logic [4:0] rsvd_29_25;
    logic       early_done_enable;
    logic [8:0] rsvd_23_15;
    logic       transfer_complete_irq_en;
    logic       rsvd_13;
    logic       end_on_eop;
    logic [1:0] rsvd_11_10;
    logic       generate_eop;
    logic       generate_sop;
    logic [7:0] rsvd_7_0;
  } desc_ctl_t;

  typedef struct packed {
    desc_ctl_t   control;
    logic [47:0] reserved;
    logic [15:0] status;
    logic [31:0] actual_bytes;
    logic [31:0] next_desc_ptr;
    logic [31:0] length;
    logic [31:0] write_addr;
    logic [31:0] read_addr;
  } desc_t;

  typedef struct packed {
    logic [26:0] rsvd_31_5;
    logic        park_mode;
    logic [1:0]  rsvd_3_2;
    logic        desc_poll_en;
    logic        run;
  } pref_ctl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_PREF_HI,
    ST_PREF_LO,
    ST_PREF_CTL,
    ST_RUN,
    ST_STOP
  } state_t;

endpackage

// File: rtl/gmm_dma_desc_gen.sv
// Combinational descriptor generator: maps ring index and direction to one
// 256-bit descriptor word.
module gmm_dma_desc_gen
  import gmm_dma_pkg::*;
#(
  parameter int unsigned NUM_SEGS     = 2,
  parameter int unsigned DESC_NUM     = 4,
  parameter int unsigned AW           = 2,
  parameter logic [31:0] SEG_BASE [4] = '{32'd0, 32'd66355200, 32'd0, 32'd0},
  parameter logic [31:0] SEG_SPAN [4] = '{32'd33177600, 32'd32, 32'd0, 32'd0},
  parameter logic [31:0] DESC_BASE    = 32'd0,
  parameter bit          IRQ_LAST     = 1'b0
) (
  input  logic [AW-1:0] idx,
  input  logic          is_read,
  output logic [255:0]  desc
);

  logic [31:0] idx_u;
  logic [31:0] frame;
  logic [1:0]  seg;
  logic [31:0] addr;
  desc_t       d;

  always_comb begin
    idx_u = 32'(idx);
    frame = idx_u / NUM_SEGS;
    seg   = 2'(idx_u % NUM_SEGS);
    addr  = SEG_BASE[seg] + frame * SEG_SPAN[seg];
    d = '0;
    d.length = SEG_SPAN[seg];
    // Last descriptor closes the ring back onto word 0.
    d.next_desc_ptr = (idx_u == DESC_NUM - 1) ? DESC_BASE
                                              : DESC_BASE + ((idx_u + 32'd1) << 5);
    d.control.go                = 1'b1;
    d.control.owned_by_hw       = 1'b1;
    d.control.early_done_enable = 1'b1;
    d.control.transfer_complete_irq_en = IRQ_LAST && (32'(seg) == NUM_SEGS - 1);
    if (is_read) begin
      d.read_addr            = addr;
      d.control.generate_sop = 1'b1;
      d.control.generate_eop = 1'b1;
    end else begin
      d.write_addr         = addr;
      d.control.end_on_eop = 1'b1;
    end
    desc = d;
  end

endmodule

// File: rtl/gmm_dma_chain_builder.sv
// Builds a ring of DMA descriptors in RAM, then programs and starts the
// descriptor prefetcher through its CSR port; stop halts and resets it.
module gmm_dma_chain_builder
  import gmm_dma_pkg::*;
#(
  parameter int unsigned FRAMES_NUM   = 2,
  parameter int unsigned NUM_SEGS     = 2,
  parameter logic [31:0] SEG_BASE [4] = '{32'd0, 32'd66355200, 32'd0, 32'd0},
  parameter logic [31:0] SEG_SPAN [4] = '{32'd33177600, 32'd32, 32'd0, 32'd0},
  parameter logic [31:0] DESC_BASE    = 32'd0,
  parameter bit          IRQ_LAST     = 1'b0,
  parameter bit          POLL_EN      = 1'b0,
  localparam int unsigned DESC_NUM    = FRAMES_NUM * NUM_SEGS,
  localparam int unsigned AW          = (DESC_NUM > 1) ? $clog2(DESC_NUM) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           is_read,
  output logic           ram_write,
  output logic [AW-1:0]  ram_addr,
  output logic [255:0]   ram_writedata,
  output logic           pref_write,
  output logic [2:0]     pref_addr,
  output logic [31:0]    pref_writedata,
  input  logic           pref_waitrequest,
  output logic           busy,
  output logic           running
);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic          stop_pend;
  logic          read_lat;
  logic [255:0]  desc;
  logic          csr_done;
  pref_ctl_t     pref_ctl;

  gmm_dma_desc_gen #(
    .NUM_SEGS (NUM_SEGS),
    .DESC_NUM (DESC_NUM),
    .AW       (AW),
    .SEG_BASE (SEG_BASE),
    .SEG_SPAN (SEG_SPAN),
    .DESC_BASE(DESC_BASE),
    .IRQ_LAST (IRQ_LAST)
  ) u_desc_gen (
    .idx    (idx),
    .is_read(read_lat),
    .desc   (desc)
  );

  assign csr_done = pref_write && !pref_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      stop_pend <= 1'b0;
      read_lat  <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        idx       <= '0;
        read_lat  <= is_read;
        stop_pend <= stop;
      end else if (state == ST_BUILD) begin
        idx <= idx + 1'b1;
      end
      if ((state == ST_BUILD || state == ST_PREF_HI || state == ST_PREF_LO ||
           state == ST_PREF_CTL) && stop)
        stop_pend <= 1'b1;
      else if (state == ST_STOP && csr_done)
        stop_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (start) state_nxt = ST_BUILD;
      ST_BUILD:    if (idx == AW'(DESC_NUM - 1)) state_nxt = ST_PREF_HI;
      ST_PREF_HI:  if (csr_done) state_nxt = ST_PREF_LO;
      ST_PREF_LO:  if (csr_done) state_nxt = ST_PREF_CTL;
      ST_PREF_CTL: if (csr_done) state_nxt = ST_RUN;
      ST_RUN:      if (stop || stop_pend) state_nxt = ST_STOP;
      ST_STOP:     if (csr_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pref_ctl              = '0;
    pref_ctl.park_mode    = 1'b1;
    pref_ctl.desc_poll_en = POLL_EN;
    pref_ctl.run          = 1'b1;
    ram_write      = 1'b0;
    ram_addr       = '0;
    ram_writedata  = '0;
    pref_write     = 1'b0;
    pref_addr      = '0;
    pref_writedata = '0;
    busy           = (state != ST_IDLE) && (state != ST_RUN);
    running        = (state == ST_RUN);
    unique case (state)
      ST_BUILD: begin
        ram_write     = 1'b1;
        ram_addr      = idx;
        ram_writedata = desc;
      end
      ST_PREF_HI: begin
        pref_write = 1'b1;
        pref_addr  = CSR_DESC_HI;
      end
      ST_PREF_LO: begin
        pref_write     = 1'b1;
        pref_addr      = CSR_DESC_LO;
        pref_writedata = DESC_BASE;
      end
      ST_PREF_CTL: begin
        pref_write     = 1'b1;
        pref_addr      = CSR_CTL;
        pref_writedata = pref_ctl;
      end
      ST_STOP: begin
        pref_write     = 1'b1;
        pref_addr      = CSR_CTL;
        pref_writedata = PREF_STOP_WORD;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gmm_dma_chain_builder.sv
// Directed bench for gmm_dma_chain_builder: default ring in both directions,
// CSR backpressure, stop handling, reset abort and a single-descriptor ring.
module tb_gmm_dma_chain_builder;

  logic         clk = 1'b0;
  logic         rst, start, stop, is_read, wr;
  logic         ram_write, pref_write, busy, running;
  logic [1:0]   ram_addr;
  logic [255:0] ram_writedata;
  logic [2:0]   pref_addr;
  logic [31:0]  pref_writedata;

  logic         start2, stop2, is_read2;
  logic         ram_write2, pref_write2, busy2, running2;
  logic [0:0]   ram_addr2;
  logic [255:0] ram_writedata2;
  logic [2:0]   pref_addr2;
  logic [31:0]  pref_writedata2;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [8:0] acc_hist = '0;

  logic [31:0] e_addr [4] = '{32'd0, 32'd66355200, 32'd33177600, 32'd66355232};
  logic [31:0] e_len  [4] = '{32'd33177600, 32'd32, 32'd33177600, 32'd32};
  logic [31:0] e_next [4] = '{32'd32, 32'd64, 32'd96, 32'd0};

  always #5 clk = ~clk;

  gmm_dma_chain_builder dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .is_read(is_read),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_writedata(ram_writedata),
    .pref_write(pref_write), .pref_addr(pref_addr), .pref_writedata(pref_writedata),
    .pref_waitrequest(wr), .busy(busy), .running(running)
  );

  gmm_dma_chain_builder #(
    .FRAMES_NUM(1), .NUM_SEGS(1),
    .SEG_BASE('{32'h0000_1000, 32'h0, 32'h0, 32'h0}),
    .SEG_SPAN('{32'h0000_0200, 32'h0, 32'h0, 32'h0}),
    .DESC_BASE(32'h0000_0400), .IRQ_LAST(1'b1), .POLL_EN(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .is_read(is_read2),
    .ram_write(ram_write2), .ram_addr(ram_addr2), .ram_writedata(ram_writedata2),
    .pref_write(pref_write2), .pref_addr(pref_addr2), .pref_writedata(pref_writedata2),
    .pref_waitrequest(1'b0), .busy(busy2), .running(running2)
  );

  always @(posedge clk) begin
    if (pref_write && !wr) begin
      acc_cnt  <= acc_cnt + 1;
      acc_hist <= {acc_hist[5:0], pref_addr};
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_write, ram_addr, ram_writedata, pref_write, pref_addr, pref_writedata, busy, running} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ram_write=%b ram_addr=%0d pref_write=%b pref_addr=%0d pref_data=%h busy=%b running=%b, required all 0",
               ram_write, ram_addr, pref_write, pref_addr, pref_writedata, busy, running);
    end
    checks++;
    if ({ram_write2, ram_writedata2, pref_write2, pref_writedata2, busy2, running2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_single: ram_write=%b pref_write=%b busy=%b running=%b, required all 0",
               ram_write2, pref_write2, busy2, running2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_csr(input string name, input logic [2:0] a, input logic [31:0] d);
    checks++;
    if (pref_write !== 1'b1 || pref_addr !== a || pref_writedata !== d || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s: pref_write=%b addr=%0d data=%h busy=%b, required 1 %0d %h 1",
               name, pref_write, pref_addr, pref_writedata, busy, a, d);
    end
  endtask

  task automatic test_chain(input logic rd);
    logic [255:0] exp;
    logic [31:0]  ctl;
    ctl = rd ? 32'hC100_0300 : 32'hC100_1000;
    is_read = rd; start = 1'b1;
    @(negedge clk); start = 1'b0; is_read = ~rd;
    for (int k = 0; k < 4; k++) begin
      exp = rd ? {ctl, 48'h0, 16'h0, 32'h0, e_next[k], e_len[k], 32'h0, e_addr[k]}
               : {ctl, 48'h0, 16'h0, 32'h0, e_next[k], e_len[k], e_addr[k], 32'h0};
      checks++;
      if (ram_write !== 1'b1 || ram_addr !== 2'(k) || ram_writedata !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL desc%0d_rd%0b: we=%b addr=%0d data=%h, required 1 %0d %h",
                 k, rd, ram_write, ram_addr, ram_writedata, k, exp);
      end
      @(negedge clk);
    end
    check_csr("csr_hi", 3'd2, 32'h0); @(negedge clk);
    check_csr("csr_lo", 3'd1, 32'h0); @(negedge clk);
    check_csr("csr_ctl", 3'd0, 32'h11); @(negedge clk);
    checks++;
    if (running !== 1'b1 || busy !== 1'b0 || ram_write !== 1'b0 || pref_write !== 1'b0) begin
      errors++;
      $display("FAIL run_state: running=%b busy=%b ram_write=%b pref_write=%b, required 1 0 0 0",
               running, busy, ram_write, pref_write);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++;
    if (running !== 1'b1 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: running=%b ram_write=%b, required 1 0", running, ram_write);
    end
  endtask

  task automatic test_stop_from_run();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check_csr("stop_csr", 3'd0, 32'h4);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || running !== 1'b0 || pref_write !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b running=%b pref_write=%b, required 0 0 0", busy, running, pref_write);
    end
  endtask

  task automatic test_waitrequest();
    int base;
    base = acc_cnt;
    is_read = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check_csr("wr_hi", 3'd2, 32'h0);
    @(negedge clk);
    wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_csr($sformatf("wr_lo_hold%0d", k), 3'd1, 32'h0);
      if (k == 3) wr = 1'b0;
      @(negedge clk);
    end
    check_csr("wr_ctl", 3'd0, 32'h11);
    @(negedge clk);
    checks++;
    if (acc_cnt - base !== 3 || acc_hist !== {3'd2, 3'd1, 3'd0} || running !== 1'b1) begin
      errors++;
      $display("FAIL wr_accepted: count=%0d hist=%o running=%b, required 3 210 1",
               acc_cnt - base, acc_hist, running);
    end
    test_stop_from_run();
  endtask

  task automatic test_stop_in_build();
    is_read = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (ram_write !== 1'b1 || ram_addr !== 2'd3) begin
      errors++;
      $display("FAIL stop_build_completes: we=%b addr=%0d, required 1 3", ram_write, ram_addr);
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL stop_pend_run: running=%b, required 1", running);
    end
    @(negedge clk);
    check_csr("stop_pend_csr", 3'd0, 32'h4);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL stop_pend_run_len: running=%b, required 0", running);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || running !== 1'b0 || pref_write !== 1'b0) begin
      errors++;
      $display("FAIL stop_pend_idle: busy=%b running=%b pref_write=%b, required 0 0 0", busy, running, pref_write);
    end
  endtask

  task automatic test_reset_mid_build();
    is_read = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_write !== 1'b1 || ram_addr !== 2'd1) begin
      errors++;
      $display("FAIL mid_build_pos: we=%b addr=%0d, required 1 1", ram_write, ram_addr);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ram_write, ram_addr, ram_writedata, pref_write, pref_addr, pref_writedata, busy, running} !== '0) begin
        errors++;
        $display("FAIL rst_abort%0d: we=%b addr=%0d pref_write=%b busy=%b, required all 0",
                 k, ram_write, ram_addr, pref_write, busy);
      end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (ram_write !== 1'b1 || ram_addr !== 2'd0 ||
        ram_writedata !== {32'hC100_0300, 48'h0, 16'h0, 32'h0, 32'd32, 32'd33177600, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rebuild_from0: we=%b addr=%0d data=%h, required 1 0 desc0", ram_write, ram_addr, ram_writedata);
    end
    repeat (7) @(negedge clk);
    test_stop_from_run();
  endtask

  task automatic test_single();
    logic [255:0] exp;
    exp = {32'hC100_4300, 48'h0, 16'h0, 32'h0, 32'h400, 32'h200, 32'h0, 32'h1000};
    is_read2 = 1'b1; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    checks++;
    if (ram_write2 !== 1'b1 || ram_addr2 !== 1'b0 || ram_writedata2 !== exp) begin
      errors++;
      $display("FAIL single_desc: we=%b addr=%0d data=%h, required 1 0 %h", ram_write2, ram_addr2, ram_writedata2, exp);
    end
    @(negedge clk);
    checks++;
    if (ram_write2 !== 1'b0 || pref_write2 !== 1'b1 || pref_addr2 !== 3'd2 || pref_writedata2 !== 32'h0) begin
      errors++;
      $display("FAIL single_hi: we=%b pw=%b addr=%0d data=%h, required 0 1 2 0", ram_write2, pref_write2, pref_addr2, pref_writedata2);
    end
    @(negedge clk);
    checks++;
    if (pref_write2 !== 1'b1 || pref_addr2 !== 3'd1 || pref_writedata2 !== 32'h400) begin
      errors++;
      $display("FAIL single_lo: pw=%b addr=%0d data=%h, required 1 1 400", pref_write2, pref_addr2, pref_writedata2);
    end
    @(negedge clk);
    checks++;
    if (pref_write2 !== 1'b1 || pref_addr2 !== 3'd0 || pref_writedata2 !== 32'h13) begin
      errors++;
      $display("FAIL single_ctl: pw=%b addr=%0d data=%h, required 1 0 13", pref_write2, pref_addr2, pref_writedata2);
    end
    @(negedge clk);
    checks++;
    if (running2 !== 1'b1) begin
      errors++;
      $display("FAIL single_run: running=%b, required 1", running2);
    end
    stop2 = 1'b1; @(negedge clk); stop2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; is_read = 1'b0; wr = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; is_read2 = 1'b0;
    test_reset();
    test_chain(1'b1);
    test_stop_from_run();
    test_chain(1'b0);
    test_stop_from_run();
    test_waitrequest();
    test_stop_in_build();
    test_reset_mid_build();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
